issue_queue: RTL and testbench
==============================

# issue_queue

Age-ordered reservation station that buffers renamed 56-bit operations in front of one functional unit. Every cycle it snoops the four result-forwarding buses, wakes up waiting operands, and issues the oldest operation whose operands are both ready. It sits between dispatch and the ALU and sequences access to that ALU.

## Interface
- DEPTH, 4: number of entries; must be at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all entries; for mispredict recovery.
- in_valid  in  1  dispatch offers `in_op`.
- in_op  in  56  operation word:
  - [55:52] op, [51:46] ROB tag, [45:40] tag A, [39:34] tag B.
  - [33:18] value A, [17:2] value B.
  - [1] A waiting, [0] B waiting.
- in_ready  out  1  queue can accept; equals count < DEPTH.
- forwardA, forwardB, forwardC, forwardD  in  23 each  result buses:
  - [22] valid, [21:16] ROB tag, [15:0] value.
- out_valid  out  1  an issuable entry exists.
- out_op  out  56  oldest issuable entry; bits [1:0] are always 00.
- out_ready  in  1  ALU accepts `out_op` this cycle.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Storage is a collapsing queue: slot 0 holds the oldest entry, and slots 0..count-1 are valid.
- Wakeup for a waiting operand:
  - Compare its tag against every forward bus whose valid bit is 1.
  - On a match, replace the 16-bit value and clear the waiting bit.
  - Bus priority is A > B > C > D.
  - A non-waiting operand is never modified.
- Wakeup applies to all stored entries every cycle, including entries that are shifting.
- Wakeup also applies to `in_op` on insert, so the stored copy already reflects this cycle's broadcasts.
- An entry is ready when bits [1:0] == 00.
- Issue selection:
  - `out_valid` = OR of the ready bits over the valid slots.
  - `out_op` = the lowest-index ready slot.
  - Selection uses stored state only, not this cycle's forwards.
- An issue handshake (`out_valid` && `out_ready`) removes selected slot k. Slots k+1..count-1 shift down by one.
- An insert handshake (`in_valid` && `in_ready`) writes at slot count, or at slot count-1 if an issue handshake occurs in the same cycle.
- count next value:
  - Unchanged if both insert and issue fire.
  - +1 on insert only.
  - −1 on issue only.
- When out_valid = 0, `out_op` is all zeros.
- Priority order is reset > flush > normal operation.
  - Flush empties the queue.
  - Flush ignores `in_valid` and issue in that cycle.
- A full queue with a simultaneous issue still deasserts `in_ready`; there is no bypass.

## Timing
- Reset values: count = 0, in_ready = 1, out_valid = 0, out_op = 0, and all slot contents = 0.
- Minimum insert-to-issue latency is 1 cycle: an op inserted ready at edge N can issue in the cycle after edge N.
- Wakeup-to-issue latency is 1 cycle: a forward in cycle N makes the entry selectable in cycle N+1.
- `in_ready`, `out_valid`, `out_op` and `count` are functions of registered state only.
- `out_op` may change combinationally only through the `out_ready` handshake outcome of the previous edge, never within a cycle.
- ROB tags are 6 bits with no wrap handling; comparison is equality only.
- After a flush at edge N: count = 0 and out_valid = 0 in cycle N+1, and `in_ready` = 1.

## Structure
- Shared package `ooo_pkg` holds:
  - Field constants: OP_MSB/LSB, ROB, TAGA, TAGB, VALA, VALB, USER bit positions.
  - Widths: OP_W = 56, FWD_W = 23, TAG_W = 6, DATA_W = 16.
- Operand-wakeup logic reuses the existing `forward_check` module:
  - One instance per slot (DEPTH).
  - One instance on the `in_op` path.
- Oldest-ready selection is a priority encoder inside `issue_queue`. The shift/insert mux is also inside `issue_queue`.

## Test plan
- Reset, then insert a ready op (in_op[1:0] = 00, ROB = 5) with out_ready = 1 → out_valid = 1 the next cycle, `out_op` ROB = 5 with [1:0] = 00, then count returns to 0.
- Insert an op waiting on A with tag 12, then pulse forwardC = {1, 6'd12, 16'hBEEF} → value A = BEEF and bit1 = 0 stored; issue occurs the following cycle.
- Forward tag 12 on forwardA (value 1111) and forwardB (value 2222) in the same cycle → A wins; value 1111 is captured.
- Fill DEPTH = 4 entries in order: ROB 1 waiting, ROB 2 ready, ROB 3 waiting, ROB 4 ready → in_ready = 0; the queue issues ROB 2, then ROB 4, in age order; ROB 1 and ROB 3 remain in slots 0 and 1.
- Issue slot 1 and insert ROB 9 in the same cycle when count = 3 → count stays 3; ROB 9 lands in slot 2; older order is preserved.
- Fill the queue, then assert flush with in_valid = 1 → next cycle count = 0, out_valid = 0, and nothing is inserted.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared definitions for the out-of-order issue path.
// Holds the operation word field positions, forward bus layout, widths,
// and the operand wakeup helper used by forward_check.
package ooo_pkg;

    localparam int unsigned OP_W   = 56;
    localparam int unsigned FWD_W  = 23;
    localparam int unsigned TAG_W  = 6;
    localparam int unsigned DATA_W = 16;

    // Operation word fields
    localparam int unsigned OP_MSB     = 55;
    localparam int unsigned OP_LSB     = 52;
    localparam int unsigned ROB_MSB    = 51;
    localparam int unsigned ROB_LSB    = 46;
    localparam int unsigned TAGA_MSB   = 45;
    localparam int unsigned TAGA_LSB   = 40;
    localparam int unsigned TAGB_MSB   = 39;
    localparam int unsigned TAGB_LSB   = 34;
    localparam int unsigned VALA_MSB   = 33;
    localparam int unsigned VALA_LSB   = 18;
    localparam int unsigned VALB_MSB   = 17;
    localparam int unsigned VALB_LSB   = 2;
    localparam int unsigned USER_WAITA = 1;
    localparam int unsigned USER_WAITB = 0;

    // Forward bus fields
    localparam int unsigned FWD_VALID    = 22;
    localparam int unsigned FWD_TAG_MSB  = 21;
    localparam int unsigned FWD_TAG_LSB  = 16;
    localparam int unsigned FWD_DATA_MSB = 15;
    localparam int unsigned FWD_DATA_LSB = 0;

    typedef struct packed {
        logic              waiting;
        logic [DATA_W-1:0] value;
    } operand_t;

    function automatic logic fwd_hit(input logic [FWD_W-1:0] fwd, input logic [TAG_W-1:0] tag);
        return fwd[FWD_VALID] && (fwd[FWD_TAG_MSB:FWD_TAG_LSB] == tag);
    endfunction

    // Bus A has the highest priority, D the lowest. Ready operands pass untouched.
    function automatic operand_t wake_operand(input operand_t          opnd,
                                              input logic [TAG_W-1:0]  tag,
                                              input logic [FWD_W-1:0]  fa,
                                              input logic [FWD_W-1:0]  fb,
                                              input logic [FWD_W-1:0]  fc,
                                              input logic [FWD_W-1:0]  fd);
        operand_t res;
        res = opnd;
        if (opnd.waiting) begin
            if (fwd_hit(fa, tag)) begin
                res = '{waiting: 1'b0, value: fa[FWD_DATA_MSB:FWD_DATA_LSB]};
            end else if (fwd_hit(fb, tag)) begin
                res = '{waiting: 1'b0, value: fb[FWD_DATA_MSB:FWD_DATA_LSB]};
            end else if (fwd_hit(fc, tag)) begin
                res = '{waiting: 1'b0, value: fc[FWD_DATA_MSB:FWD_DATA_LSB]};
            end else if (fwd_hit(fd, tag)) begin
                res = '{waiting: 1'b0, value: fd[FWD_DATA_MSB:FWD_DATA_LSB]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Dispatch / forward / issue signal bundle for issue_queue.
// master: dispatch side and ALU side (drives in_*, forwards, out_ready, flush).
// slave:  the queue itself (drives in_ready, out_valid, out_op, count).
interface issue_queue_if #(
    parameter int unsigned DEPTH = 4
);
    import ooo_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic [OP_W-1:0]  in_op;
    logic             in_ready;
    logic [FWD_W-1:0] forwardA;
    logic [FWD_W-1:0] forwardB;
    logic [FWD_W-1:0] forwardC;
    logic [FWD_W-1:0] forwardD;
    logic             out_valid;
    logic [OP_W-1:0]  out_op;
    logic             out_ready;
    logic [CNT_W-1:0] count;

    modport master (
        output flush, in_valid, in_op, forwardA, forwardB, forwardC, forwardD, out_ready,
        input  in_ready, out_valid, out_op, count
    );

    modport slave (
        input  flush, in_valid, in_op, forwardA, forwardB, forwardC, forwardD, out_ready,
        output in_ready, out_valid, out_op, count
    );

endinterface

// File: rtl/forward_check.sv
// Operand wakeup for one operation word.
// Ports: op_in  - stored/incoming operation word
//        fwd_a..fwd_d - result forwarding buses, A highest priority
//        op_out - op_in with any matched waiting operand filled in and its wait bit cleared
module forward_check
    import ooo_pkg::*;
(
    input  logic [OP_W-1:0]  op_in,
    input  logic [FWD_W-1:0] fwd_a,
    input  logic [FWD_W-1:0] fwd_b,
    input  logic [FWD_W-1:0] fwd_c,
    input  logic [FWD_W-1:0] fwd_d,
    output logic [OP_W-1:0]  op_out
);

    operand_t opnd_a;
    operand_t opnd_b;

    always_comb begin
        opnd_a = wake_operand('{waiting: op_in[USER_WAITA], value: op_in[VALA_MSB:VALA_LSB]},
                              op_in[TAGA_MSB:TAGA_LSB], fwd_a, fwd_b, fwd_c, fwd_d);
        opnd_b = wake_operand('{waiting: op_in[USER_WAITB], value: op_in[VALB_MSB:VALB_LSB]},
                              op_in[TAGB_MSB:TAGB_LSB], fwd_a, fwd_b, fwd_c, fwd_d);
        op_out                     = op_in;
        op_out[VALA_MSB:VALA_LSB]  = opnd_a.value;
        op_out[VALB_MSB:VALB_LSB]  = opnd_b.value;
        op_out[USER_WAITA]         = opnd_a.waiting;
        op_out[USER_WAITB]         = opnd_b.waiting;
    end

endmodule

// File: rtl/issue_queue.sv
// Age-ordered collapsing reservation station in front of one functional unit.
// Ports: clk, reset (sync, active-high), bus (issue_queue_if.slave):
//   flush, in_valid/in_op/in_ready (dispatch), forwardA..D (wakeup buses),
//   out_valid/out_op/out_ready (issue to ALU), count (occupancy).
// Slot 0 is the oldest entry; slots 0..count-1 are valid.
module issue_queue
    import ooo_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input logic         clk,
    input logic         reset,
    issue_queue_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [OP_W-1:0]  slots_q   [DEPTH];
    logic [OP_W-1:0]  slots_d   [DEPTH];
    logic [OP_W-1:0]  woken     [DEPTH];
    logic [OP_W-1:0]  shift_src [DEPTH];
    logic [OP_W-1:0]  in_woken;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] ins_pos;
    logic [DEPTH-1:0] ready_vec;
    logic [IDX_W-1:0] sel_idx;
    logic             any_ready;
    logic             do_issue;
    logic             do_insert;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        forward_check u_fc (
            .op_in  (slots_q[g]),
            .fwd_a  (bus.forwardA),
            .fwd_b  (bus.forwardB),
            .fwd_c  (bus.forwardC),
            .fwd_d  (bus.forwardD),
            .op_out (woken[g])
        );

        // Readiness comes from stored state only, so this cycle's forwards
        // affect selection one cycle later.
        assign ready_vec[g] = (CNT_W'(g) < count_q) &&
                              (slots_q[g][USER_WAITA] == 1'b0) &&
                              (slots_q[g][USER_WAITB] == 1'b0);

        // Source for slot g when everything at or above the issued slot collapses.
        if (g < DEPTH - 1) begin : g_mid
            assign shift_src[g] = woken[g+1];
        end else begin : g_top
            assign shift_src[g] = '0;
        end
    end

    forward_check u_fc_in (
        .op_in  (bus.in_op),
        .fwd_a  (bus.forwardA),
        .fwd_b  (bus.forwardB),
        .fwd_c  (bus.forwardC),
        .fwd_d  (bus.forwardD),
        .op_out (in_woken)
    );

    // Oldest-ready priority encoder: the lowest index wins.
    always_comb begin
        sel_idx   = '0;
        any_ready = 1'b0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                sel_idx   = IDX_W'(i);
                any_ready = 1'b1;
            end
        end
    end

    assign bus.in_ready  = (count_q < CNT_W'(DEPTH));
    assign bus.out_valid = any_ready;
    assign bus.out_op    = any_ready ? slots_q[sel_idx] : '0;
    assign bus.count     = count_q;

    assign do_issue  = any_ready && bus.out_ready;
    assign do_insert = bus.in_valid && bus.in_ready;
    // An issue in the same cycle frees one slot below the tail.
    assign ins_pos   = do_issue ? (count_q - CNT_W'(1)) : count_q;

    always_comb begin
        count_d = count_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            slots_d[i] = woken[i];
        end

        if (do_issue) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (IDX_W'(i) >= sel_idx) begin
                    slots_d[i] = shift_src[i];
                end
            end
        end

        if (do_insert) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (CNT_W'(i) == ins_pos) begin
                    slots_d[i] = in_woken;
                end
            end
        end

        if (do_insert && !do_issue) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_issue && !do_insert) begin
            count_d = count_q - CNT_W'(1);
        end

        // Keep unoccupied slots at zero so stale words never linger.
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (CNT_W'(i) >= count_d) begin
                slots_d[i] = '0;
            end
        end

        if (bus.flush) begin
            count_d = '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                slots_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                slots_q[i] <= slots_d[i];
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for issue_queue (DEPTH = 4).
module tb_issue_queue;
    import ooo_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    issue_queue_if #(.DEPTH(4)) bus ();

    issue_queue #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OP_W-1:0] mk_op(input logic [5:0] rob, input logic [5:0] ta,
                                              input logic [5:0] tb, input logic [15:0] va,
                                              input logic [15:0] vb, input logic wa,
                                              input logic wb);
        return {4'h3, rob, ta, tb, va, vb, wa, wb};
    endfunction

    function automatic logic [FWD_W-1:0] mk_fwd(input logic [5:0] tag, input logic [15:0] val);
        return {1'b1, tag, val};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_fwd();
        bus.forwardA = '0;
        bus.forwardB = '0;
        bus.forwardC = '0;
        bus.forwardD = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.out_ready = 1'b0;
        clr_fwd();
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_op", 64'(bus.out_op), 64'd0);

        // Ready op issues the cycle after insert
        bus.in_valid  = 1'b1;
        bus.in_op     = mk_op(6'd5, 6'd0, 6'd0, 16'h1234, 16'h5678, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_out_op", 64'(bus.out_op), 64'(mk_op(6'd5, 6'd0, 6'd0, 16'h1234, 16'h5678, 1'b0, 1'b0)));
        chk("t1_count", 64'(bus.count), 64'd1);
        step();
        chk("t1_count_after", 64'(bus.count), 64'd0);
        chk("t1_out_valid_after", 64'(bus.out_valid), 64'd0);

        // Wakeup via forwardC
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_op     = mk_op(6'd6, 6'd12, 6'd0, 16'h0000, 16'h0007, 1'b1, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk("t2_count", 64'(bus.count), 64'd1);
        chk("t2_not_ready", 64'(bus.out_valid), 64'd0);
        bus.forwardC = mk_fwd(6'd12, 16'hBEEF);
        step();
        clr_fwd();
        chk("t2_woken_valid", 64'(bus.out_valid), 64'd1);
        chk("t2_woken_op", 64'(bus.out_op), 64'(mk_op(6'd6, 6'd12, 6'd0, 16'hBEEF, 16'h0007, 1'b0, 1'b0)));
        bus.out_ready = 1'b1;
        step();
        chk("t2_count_after", 64'(bus.count), 64'd0);

        // A beats B on the same tag; non-waiting B keeps its value
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_op     = mk_op(6'd7, 6'd12, 6'd12, 16'h0000, 16'h5555, 1'b1, 1'b0);
        step();
        bus.in_valid = 1'b0;
        bus.forwardA = mk_fwd(6'd12, 16'h1111);
        bus.forwardB = mk_fwd(6'd12, 16'h2222);
        step();
        clr_fwd();
        chk("t3_prio_op", 64'(bus.out_op), 64'(mk_op(6'd7, 6'd12, 6'd12, 16'h1111, 16'h5555, 1'b0, 1'b0)));
        bus.out_ready = 1'b1;
        step();
        chk("t3_count_after", 64'(bus.count), 64'd0);

        // Wakeup on the insert path via forwardD
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_op     = mk_op(6'd8, 6'd0, 6'd20, 16'h0AAA, 16'h0000, 1'b0, 1'b1);
        bus.forwardD  = mk_fwd(6'd20, 16'hABCD);
        step();
        bus.in_valid = 1'b0;
        clr_fwd();
        chk("t3b_ins_wake_valid", 64'(bus.out_valid), 64'd1);
        chk("t3b_ins_wake_op", 64'(bus.out_op), 64'(mk_op(6'd8, 6'd0, 6'd20, 16'h0AAA, 16'hABCD, 1'b0, 1'b0)));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("t3b_count_after", 64'(bus.count), 64'd0);

        // Fill: ROB1 waiting, ROB2 ready, ROB3 waiting, ROB4 ready
        bus.in_valid = 1'b1;
        bus.in_op    = mk_op(6'd1, 6'd30, 6'd0, 16'h0, 16'h0, 1'b1, 1'b0);
        step();
        bus.in_op    = mk_op(6'd2, 6'd0, 6'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
        bus.in_op    = mk_op(6'd3, 6'd31, 6'd0, 16'h0, 16'h0, 1'b1, 1'b0);
        step();
        bus.in_op    = mk_op(6'd4, 6'd0, 6'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
        chk("t4_full_count", 64'(bus.count), 64'd4);
        chk("t4_full_in_ready", 64'(bus.in_ready), 64'd0);
        chk("t4_sel_rob2", 64'(bus.out_op[ROB_MSB:ROB_LSB]), 64'd2);
        // Full with simultaneous issue: no bypass, ROB15 is not taken
        bus.in_op     = mk_op(6'd15, 6'd0, 6'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("t4_nobypass_count", 64'(bus.count), 64'd3);
        chk("t4_sel_rob4", 64'(bus.out_op[ROB_MSB:ROB_LSB]), 64'd4);
        step();
        bus.out_ready = 1'b0;
        chk("t4_remain_count", 64'(bus.count), 64'd2);
        chk("t4_none_ready", 64'(bus.out_valid), 64'd0);
        chk("t4_none_op", 64'(bus.out_op), 64'd0);
        chk("t4_slot0_rob1", 64'(dut.slots_q[0][ROB_MSB:ROB_LSB]), 64'd1);
        chk("t4_slot1_rob3", 64'(dut.slots_q[1][ROB_MSB:ROB_LSB]), 64'd3);

        // Wake ROB3 while inserting ROB10, then issue slot 1 and insert ROB9 together
        bus.forwardA = mk_fwd(6'd31, 16'h3333);
        bus.in_valid = 1'b1;
        bus.in_op    = mk_op(6'd10, 6'd40, 6'd0, 16'h0, 16'h0, 1'b1, 1'b0);
        step();
        clr_fwd();
        chk("t5_count3", 64'(bus.count), 64'd3);
        chk("t5_sel_rob3", 64'(bus.out_op), 64'(mk_op(6'd3, 6'd31, 6'd0, 16'h3333, 16'h0, 1'b0, 1'b0)));
        bus.out_ready = 1'b1;
        bus.in_op     = mk_op(6'd9, 6'd41, 6'd0, 16'h0, 16'h0, 1'b1, 1'b0);
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("t5_count_same", 64'(bus.count), 64'd3);
        chk("t5_slot0_rob1", 64'(dut.slots_q[0][ROB_MSB:ROB_LSB]), 64'd1);
        chk("t5_slot1_rob10", 64'(dut.slots_q[1][ROB_MSB:ROB_LSB]), 64'd10);
        chk("t5_slot2_rob9", 64'(dut.slots_q[2][ROB_MSB:ROB_LSB]), 64'd9);
        chk("t5_none_ready", 64'(bus.out_valid), 64'd0);

        // Fill then flush with in_valid high
        bus.in_valid = 1'b1;
        bus.in_op    = mk_op(6'd11, 6'd0, 6'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
        chk("t6_full", 64'(bus.count), 64'd4);
        chk("t6_sel_rob11", 64'(bus.out_op[ROB_MSB:ROB_LSB]), 64'd11);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_op     = mk_op(6'd12, 6'd0, 6'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("t6_flush_count", 64'(bus.count), 64'd0);
        chk("t6_flush_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_flush_in_ready", 64'(bus.in_ready), 64'd1);
        chk("t6_flush_op", 64'(bus.out_op), 64'd0);

        // Flush while not full also drops a same-cycle insert
        bus.in_valid = 1'b1;
        bus.in_op    = mk_op(6'd13, 6'd0, 6'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
        chk("t7_count1", 64'(bus.count), 64'd1);
        bus.flush = 1'b1;
        bus.in_op = mk_op(6'd14, 6'd0, 6'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("t7_flush_count", 64'(bus.count), 64'd0);
        chk("t7_flush_valid", 64'(bus.out_valid), 64'd0);
        step();
        chk("t7_stays_empty", 64'(bus.count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
